// File: rtl/gopf_mul_loader_if.sv
// Word-bus and GOPF_MUL-side signal bundle for gopf_mul_loader.
// The loader takes the slave modport. The ALU1 driver and the multiplier take the master modport.
interface gopf_mul_loader_if #(
    parameter int M = 144,
    parameter int W = 16
);
    logic         cmd_valid;
    logic [1:0]   cmd_op;
    logic         cmd_ready;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_last;
    logic         out_ready;
    logic         busy;
    logic         mod_valid;
    logic         err;
    logic         gm_start;
    logic [0:M-1] gm_multiplicand;
    logic [0:M-1] gm_multiplier;
    logic [0:M-1] gm_mod;
    logic [0:M-1] gm_mul_out;
    logic         gm_mul_done;

    modport slave (
        input  cmd_valid, cmd_op, in_valid, in_data, out_ready, gm_mul_out, gm_mul_done,
        output cmd_ready, in_ready, out_valid, out_data, out_last, busy, mod_valid, err,
               gm_start, gm_multiplicand, gm_multiplier, gm_mod
    );

    modport master (
        output cmd_valid, cmd_op, in_valid, in_data, out_ready, gm_mul_out, gm_mul_done,
        input  cmd_ready, in_ready, out_valid, out_data, out_last, busy, mod_valid, err,
               gm_start, gm_multiplicand, gm_multiplier, gm_mod
    );
endinterface

// File: rtl/gopf_mul_loader.sv
// Word-serial front end for the GF((2^16)^9) multiplier.
// It loads the modulus and the operands one word at a time, runs one multiply, and streams the product back out.
module gopf_mul_loader #(
    parameter int M = 144,
    parameter int W = 16
) (
    input  logic              clk,
    input  logic              rst_b,
    gopf_mul_loader_if.slave  bus
);
    localparam int N  = M / W;
    localparam int CW = $clog2(N);

    typedef enum logic [2:0] {
        IDLE, LOAD_MOD, LOAD_A, LOAD_B, START, WAIT, DRAIN
    } state_t;

    state_t        state, nxt;
    logic [CW-1:0] wcnt;
    logic [0:M-1]  mod_reg, a_reg, b_reg, res_reg;
    logic          mod_valid, err;
    logic          wr, inc, cap, bad, wlast;

    assign wlast = (wcnt == CW'(N - 1));

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) state <= IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        wr  = 1'b0;
        inc = 1'b0;
        cap = 1'b0;
        bad = 1'b0;
        case (state)
            IDLE: if (bus.cmd_valid) begin
                if (bus.cmd_op == 2'd0)                  nxt = LOAD_MOD;
                else if (bus.cmd_op == 2'd1 && mod_valid) nxt = LOAD_A;
                else                                     bad = 1'b1;
            end
            LOAD_MOD, LOAD_A, LOAD_B: if (bus.in_valid) begin
                wr  = 1'b1;
                inc = 1'b1;
                if (wlast) begin
                    if (state == LOAD_MOD)    nxt = IDLE;
                    else if (state == LOAD_A) nxt = LOAD_B;
                    else                      nxt = START;
                end
            end
            START: nxt = WAIT;
            WAIT: if (bus.gm_mul_done) begin
                cap = 1'b1;
                nxt = DRAIN;
            end
            DRAIN: if (bus.out_ready) begin
                inc = 1'b1;
                if (wlast) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    // The operand registers drive the multiplier directly. They change only in the load states, so they hold steady from START until the result is captured.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wcnt      <= '0;
            mod_reg   <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            res_reg   <= '0;
            mod_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            err <= bad;
            if (inc) wcnt <= wlast ? '0 : wcnt + 1'b1;
            if (wr) begin
                for (int k = 0; k < N; k++) begin
                    if (wcnt == CW'(k)) begin
                        case (state)
                            LOAD_MOD: mod_reg[W*k +: W] <= bus.in_data;
                            LOAD_A:   a_reg[W*k +: W]   <= bus.in_data;
                            default:  b_reg[W*k +: W]   <= bus.in_data;
                        endcase
                    end
                end
            end
            if (wr && wlast && state == LOAD_MOD) mod_valid <= 1'b1;
            if (cap) res_reg <= bus.gm_mul_out;
        end
    end

    always_comb begin
        bus.out_data = '0;
        for (int k = 0; k < N; k++)
            if (wcnt == CW'(k)) bus.out_data = res_reg[W*k +: W];
    end

    assign bus.cmd_ready       = (state == IDLE);
    assign bus.in_ready        = (state == LOAD_MOD) || (state == LOAD_A) || (state == LOAD_B);
    assign bus.out_valid       = (state == DRAIN);
    assign bus.out_last        = (state == DRAIN) && wlast;
    assign bus.busy            = (state != IDLE);
    assign bus.mod_valid       = mod_valid;
    assign bus.err             = err;
    assign bus.gm_start        = (state == START);
    assign bus.gm_multiplicand = a_reg;
    assign bus.gm_multiplier   = b_reg;
    assign bus.gm_mod          = mod_reg;
endmodule
